multicycle_alu: RTL

- 16-bit signed ALU stage for the accumulator datapath, directly upstream of the ALU output register.
- Single-cycle ops (add/sub/logic/compare/shift) complete in 1 cycle. Multiply is iterative: radix-2 shift-add over 16 cycles.
- `result` drives the ALU output register data input. `done` drives its write enable: one-cycle pulse, aligned with a valid `result`.
- start/busy/done handshake lets the control FSM stall on multi-cycle ops.

---
 rtl/multicycle_alu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : 16-bit signed ALU; 1-cycle ops, iterative shift-add multiply.
// Revision : 1.0
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int          c_SH_W    = $clog2(WIDTH);
    localparam int          c_CNT_W   = $clog2(MUL_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_CYCLES);

    localparam logic [0:0]  c_S_IDLE  = 1'b0;
    localparam logic [0:0]  c_S_MUL   = 1'b1;

    localparam logic [3:0]  c_OP_ADD  = 4'd0;
    localparam logic [3:0]  c_OP_SUB  = 4'd1;
    localparam logic [3:0]  c_OP_AND  = 4'd2;
    localparam logic [3:0]  c_OP_OR   = 4'd3;
    localparam logic [3:0]  c_OP_SLT  = 4'd4;
    localparam logic [3:0]  c_OP_SLL  = 4'd5;
    localparam logic [3:0]  c_OP_SRA  = 4'd6;
    localparam logic [3:0]  c_OP_MUL  = 4'd7;

    logic [0:0]           r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]       r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_sign;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_done;

    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_res;
    logic                 w_ovf;
    logic [WIDTH:0]       w_a_ext;
    logic [WIDTH:0]       w_b_ext;
    logic [WIDTH:0]       w_a_mag;
    logic [WIDTH:0]       w_b_mag;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_prod_hi;
    logic                 w_prod_ovf;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLL: w_res = a << b[c_SH_W-1:0];
            c_OP_SRA: w_res = $unsigned($signed(a) >>> b[c_SH_W-1:0]);
            default:  begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    // 17-bit magnitudes so that -32768 has a representable absolute value
    assign w_a_ext = {a[WIDTH-1], a};
    assign w_b_ext = {b[WIDTH-1], b};
    assign w_a_mag = a[WIDTH-1] ? -w_a_ext : w_a_ext;
    assign w_b_mag = b[WIDTH-1] ? -w_b_ext : w_b_ext;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_sign ? -r_acc : r_acc;
    assign w_prod_hi  = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_prod_ovf = !((&w_prod_hi) || !(|w_prod_hi));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        if (op == c_OP_MUL) begin
                            r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_mcand  <= {{(WIDTH-1){1'b0}}, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_acc    <= '0;
                            r_count  <= '0;
                            r_state  <= c_S_MUL;
                        end else begin
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                            r_ovf    <= w_ovf;
                            r_done   <= 1'b1;
                        end
                    end
                end
                c_S_MUL: begin
                    // One extra cycle after the last iteration applies the sign
                    if (r_count == c_CNT_LAST) begin
                        r_result <= w_prod[WIDTH-1:0];
                        r_zero   <= (w_prod[WIDTH-1:0] == '0);
                        r_ovf    <= w_prod_ovf;
                        r_done   <= 1'b1;
                        r_state  <= c_S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == c_S_MUL);
    assign done     = r_done;
    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_ovf;

endmodule
`default_nettype wire
